alu_cmd_loader: RTL

ALU_CMD_LOADER -- requirements
Module: alu_cmd_loader

---
 rtl/alu_cmd_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_cmd_loader.sv
// alu_cmd_loader: frames a host byte stream (header, A, B) into ALU commands.
// Registered A/B/op_sel update together with a one-cycle issue strobe, followed
// by RESULT_WAIT idle cycles. Bad headers pulse err and bump a saturating count.
// Optional macro ALU_CMD_PARITY_EN: header[3] must equal header[1]^header[0].
module alu_cmd_loader #(
  parameter int unsigned RESULT_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [1:0] op_sel,
  output logic       issue,
  output logic       busy,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_WAIT
  } state_t;

  // WAIT counts down to zero, so it is loaded with one less than its length.
  localparam logic [3:0] WAIT_LOAD = (RESULT_WAIT == 0) ? 4'd0 : 4'(RESULT_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [7:0] sh_a;
  logic [1:0] sh_op;
  logic       accept;
  logic       hdr_ok;
  logic       hdr_bad;

  // Handshake and header qualification.
  always_comb begin
    in_ready = !reset && (state == S_IDLE || state == S_GET_A || state == S_GET_B);
    accept   = in_valid && in_ready;
`ifdef ALU_CMD_PARITY_EN
    hdr_ok   = (in_data[7:4] == 4'hA) && (in_data[3] == (in_data[1] ^ in_data[0]));
`else
    hdr_ok   = (in_data[7:4] == 4'hA);
`endif
    hdr_bad  = accept && (state == S_IDLE) && !hdr_ok;
    issue    = (state == S_ISSUE);
    busy     = (state != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept && hdr_ok) state_nxt = S_GET_A;
      S_GET_A: if (accept)           state_nxt = S_GET_B;
      S_GET_B: if (accept)           state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (RESULT_WAIT == 0) ? S_IDLE : S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow capture of header/A; outputs update together as ISSUE is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a   <= '0;
      sh_op  <= '0;
      A      <= '0;
      B      <= '0;
      op_sel <= '0;
    end else begin
      if (accept && state == S_IDLE && hdr_ok) sh_op <= in_data[1:0];
      if (accept && state == S_GET_A)          sh_a  <= in_data;
      if (accept && state == S_GET_B) begin
        A      <= sh_a;
        B      <= in_data;
        op_sel <= sh_op;
      end
    end
  end

  // WAIT duration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= WAIT_LOAD;
    else if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
  end

  // Header rejection pulse and saturating error count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= hdr_bad;
      if (hdr_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule
